// File: rtl/packet_sorter.sv
// Purpose : routes decoded HDMI data-island packets (ACR -> N/CTS, audio sample -> stereo FIFO, AVI -> VIC).
// Latency : ACR/AVI results at the sampling edge T; audio slot i staged at T+1+i, FIFO head visible after T+2+i.
// Backpress: audio_sample_valid/ready on the FIFO head; entries that find the FIFO full are dropped and counted.
//
// Ports:
//   clk_pixel, reset_n                  - pixel clock, async active-low reset
//   packet_valid, packet_ecc_ok         - packet strobe and its ECC qualifier
//   header[23:0], sub[223:0]            - HB0..HB2 and four 56-bit subpackets
//   audio_sample_word/_block_start      - FIFO head {right,left} and IEC60958 B flag (zero while empty)
//   audio_sample_valid/_ready           - FIFO head handshake
//   acr_n, acr_cts, acr_update          - last ACR values and capture pulse
//   vic, avi_valid                      - last checksum-verified AVI VIC, sticky valid
//   overflow_count, ecc_error_count     - saturating event counters
module packet_sorter #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                           clk_pixel,
    input  logic                           reset_n,
    input  logic                           packet_valid,
    input  logic                           packet_ecc_ok,
    input  logic [23:0]                    header,
    input  logic [223:0]                   sub,
    output logic [2*AUDIO_BIT_WIDTH-1:0]   audio_sample_word,
    output logic                           audio_sample_block_start,
    output logic                           audio_sample_valid,
    input  logic                           audio_sample_ready,
    output logic [19:0]                    acr_n,
    output logic [19:0]                    acr_cts,
    output logic                           acr_update,
    output logic [6:0]                     vic,
    output logic                           avi_valid,
    output logic [7:0]                     overflow_count,
    output logic [7:0]                     ecc_error_count
);

    localparam int W  = AUDIO_BIT_WIDTH;
    localparam int EW = 2 * W + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_UNPACK} state_t;

    // ------------------------------------------------------------------
    // Packet classification
    // ------------------------------------------------------------------
    logic       w_pkt_ok;
    logic       w_is_acr;
    logic       w_is_avi;
    logic       w_aud_start;
    logic [7:0] w_csum;

    assign w_pkt_ok    = packet_valid & packet_ecc_ok;
    assign w_is_acr    = w_pkt_ok && (header[7:0] == 8'h01);
    assign w_is_avi    = w_pkt_ok && (header[7:0] == 8'h82);
    // HB1[4] selects layout 1 (multichannel), which this sink does not handle.
    assign w_aud_start = w_pkt_ok && (header[7:0] == 8'h02) && !header[12];

    // AVI checksum: three header bytes plus PB0..PB27 (sub bytes 0..27), mod 256.
    always_comb begin
        w_csum = header[7:0] + header[15:8] + header[23:16];
        for (int j = 0; j < 28; j++) begin
            w_csum = w_csum + sub[8*j +: 8];
        end
    end

    // ------------------------------------------------------------------
    // ACR / AVI / ECC registers
    // ------------------------------------------------------------------
    logic [19:0] r_acr_n;
    logic [19:0] r_acr_cts;
    logic        r_acr_upd;
    logic [6:0]  r_vic;
    logic        r_avi_vld;
    logic [7:0]  r_ecc_cnt;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_acr_n   <= '0;
            r_acr_cts <= '0;
            r_acr_upd <= 1'b0;
            r_vic     <= '0;
            r_avi_vld <= 1'b0;
            r_ecc_cnt <= '0;
        end else begin
            r_acr_upd <= w_is_acr;
            if (w_is_acr) begin
                r_acr_cts <= {sub[11:8], sub[23:16], sub[31:24]};
                r_acr_n   <= {sub[35:32], sub[47:40], sub[55:48]};
            end
            if (w_is_avi && (w_csum == 8'h00)) begin
                r_vic     <= sub[38:32];
                r_avi_vld <= 1'b1;
            end
            if (packet_valid && !packet_ecc_ok && (r_ecc_cnt != 8'hFF)) begin
                r_ecc_cnt <= r_ecc_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Audio unpack FSM
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_slot;
    logic [3:0]     r_present;
    logic [7:0]     r_hb2;
    logic [223:0]   r_sub;
    logic           w_unpacking;
    logic           w_slot_push;
    logic [3:0]     w_rest;
    logic [2:0]     w_abandon_cnt;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_aud_start) begin
            w_state_nxt = S_UNPACK;
        end else if ((r_state == S_UNPACK) && (r_slot == 2'd3)) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_unpacking   = (r_state == S_UNPACK);
        w_slot_push   = w_unpacking & r_present[r_slot];
        // The current slot is still processed on a restart edge; only the
        // slots above it are abandoned.
        w_rest        = r_present & (4'b1110 << r_slot);
        w_abandon_cnt = 3'd0;
        if (w_unpacking && w_aud_start) begin
            w_abandon_cnt = {2'b0, w_rest[0]} + {2'b0, w_rest[1]}
                          + {2'b0, w_rest[2]} + {2'b0, w_rest[3]};
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_slot    <= '0;
            r_present <= '0;
            r_hb2     <= '0;
            r_sub     <= '0;
        end else if (w_aud_start) begin
            r_slot    <= '0;
            r_present <= header[11:8];
            r_hb2     <= header[23:16];
            r_sub     <= sub;
        end else if (w_unpacking) begin
            r_slot    <= r_slot + 2'd1;
        end
    end

    // Slot extraction: 24-bit MSB-aligned left/right fields, low bits discarded.
    logic [55:0]  w_sp;
    logic [W-1:0] w_left;
    logic [W-1:0] w_right;
    logic         w_flat;
    logic         w_bflag;
    logic         w_unused;

    assign w_sp     = r_sub[56*r_slot +: 56];
    assign w_flat   = r_hb2[{1'b0, r_slot}];
    assign w_bflag  = r_hb2[{1'b1, r_slot}];
    assign w_left   = w_flat ? '0 : w_sp[23 -: W];
    assign w_right  = w_flat ? '0 : w_sp[47 -: W];
    assign w_unused = ^w_sp;

    // One-entry staging register between the slot walker and the FIFO.
    logic          r_stg_vld;
    logic [EW-1:0] r_stg_dat;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_stg_vld <= 1'b0;
            r_stg_dat <= '0;
        end else begin
            r_stg_vld <= w_slot_push;
            if (w_slot_push) begin
                r_stg_dat <= {w_bflag, w_right, w_left};
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO (first-word-fall-through, extra pointer bit for full)
    // ------------------------------------------------------------------
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_ok;
    logic          w_drop;
    logic [EW-1:0] w_head;
    logic [8:0]    w_ovf_sum;
    logic [7:0]    r_ovf_cnt;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && audio_sample_ready;
    assign w_wr_ok = r_stg_vld && (!w_full || w_pop);
    assign w_drop  = r_stg_vld && !w_wr_ok;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_pixel) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_stg_dat;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)   r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // A full-FIFO drop and abandoned slots of a restarted packet can coincide.
    assign w_ovf_sum = {1'b0, r_ovf_cnt} + {8'b0, w_drop} + {6'b0, w_abandon_cnt};

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_cnt <= '0;
        end else begin
            r_ovf_cnt <= w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign audio_sample_valid       = !w_empty;
    assign audio_sample_word        = w_empty ? '0   : w_head[2*W-1:0];
    assign audio_sample_block_start = w_empty ? 1'b0 : w_head[EW-1];
    assign acr_n                    = r_acr_n;
    assign acr_cts                  = r_acr_cts;
    assign acr_update               = r_acr_upd;
    assign vic                      = r_vic;
    assign avi_valid                = r_avi_vld;
    assign overflow_count           = r_ovf_cnt;
    assign ecc_error_count          = r_ecc_cnt;

endmodule

// File: tb/tb_packet_sorter.sv
module tb_packet_sorter;

    logic         clk_pixel = 1'b0;
    logic         reset_n;
    logic         packet_valid;
    logic         packet_ecc_ok;
    logic [23:0]  header;
    logic [223:0] sub;
    logic [31:0]  audio_sample_word;
    logic         audio_sample_block_start;
    logic         audio_sample_valid;
    logic         audio_sample_ready;
    logic [19:0]  acr_n;
    logic [19:0]  acr_cts;
    logic         acr_update;
    logic [6:0]   vic;
    logic         avi_valid;
    logic [7:0]   overflow_count;
    logic [7:0]   ecc_error_count;

    packet_sorter #(.AUDIO_BIT_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk_pixel                (clk_pixel),
        .reset_n                  (reset_n),
        .packet_valid             (packet_valid),
        .packet_ecc_ok            (packet_ecc_ok),
        .header                   (header),
        .sub                      (sub),
        .audio_sample_word        (audio_sample_word),
        .audio_sample_block_start (audio_sample_block_start),
        .audio_sample_valid       (audio_sample_valid),
        .audio_sample_ready       (audio_sample_ready),
        .acr_n                    (acr_n),
        .acr_cts                  (acr_cts),
        .acr_update               (acr_update),
        .vic                      (vic),
        .avi_valid                (avi_valid),
        .overflow_count           (overflow_count),
        .ecc_error_count          (ecc_error_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_tests = 0;
    int n_fail  = 0;

    // Words popped by the consumer, {block_start, word}, captured mid-cycle.
    logic [32:0] q_pop[$];
    always @(negedge clk_pixel) begin
        if (reset_n && audio_sample_valid && audio_sample_ready) begin
            q_pop.push_back({audio_sample_block_start, audio_sample_word});
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Called between edges; returns 1ns after the sampling edge T.
    task automatic send_pkt(input logic [23:0] h, input logic [223:0] s, input logic ok);
        header        = h;
        sub           = s;
        packet_ecc_ok = ok;
        packet_valid  = 1'b1;
        @(posedge clk_pixel);
        #1;
        packet_valid  = 1'b0;
        packet_ecc_ok = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_pixel);
        #1;
    endtask

    function automatic logic [15:0] left16(input int p, input int i);
        return 16'(16'h1111 * (i + 1) + p);
    endfunction

    function automatic logic [31:0] exp_word(input int p, input int i);
        logic [15:0] l;
        l = left16(p, i);
        return {~l, l};
    endfunction

    function automatic logic [223:0] aud_sub(input int p);
        logic [223:0] s;
        logic [23:0]  l24;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            l24 = {left16(p, i), 8'h00};
            s[56*i +: 24]      = l24;
            s[56*i + 24 +: 24] = ~l24;
        end
        return s;
    endfunction

    typedef struct {
        string        nm;
        logic [23:0]  hdr;
        logic [223:0] sb;
        logic         ok;
        logic [19:0]  n;
        logic [19:0]  cts;
        logic         upd;
        logic [6:0]   vic;
        logic         avi;
        logic [7:0]   ecc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [223:0] s_acr1, s_acr2, s_avi16, s_avi4, s_avi16_bad;
        s_acr1      = {168'h0, 56'h001800A0860100};
        s_acr2      = {168'h0, 56'hAB89A75634F200};
        s_avi16     = {168'h0, 56'h0000100000005F};
        s_avi4      = {168'h0, 56'h0000040000006B};
        s_avi16_bad = {168'h0, 56'h0000100000005E};

        //          name        header      sub          ok    N         CTS       upd  vic  avi  ecc
        tbl[0] = '{"acr_ok",    24'h000001, s_acr1,      1'b1, 20'h01800, 20'h186A0, 1'b1, 7'd0,  1'b0, 8'd0};
        tbl[1] = '{"acr_ecc",   24'h000001, s_acr2,      1'b0, 20'h01800, 20'h186A0, 1'b0, 7'd0,  1'b0, 8'd1};
        tbl[2] = '{"type83",    24'h0D0183, s_acr2,      1'b1, 20'h01800, 20'h186A0, 1'b0, 7'd0,  1'b0, 8'd1};
        tbl[3] = '{"avi16",     24'h0D0282, s_avi16,     1'b1, 20'h01800, 20'h186A0, 1'b0, 7'd16, 1'b1, 8'd1};
        tbl[4] = '{"avi4",      24'h0D0282, s_avi4,      1'b1, 20'h01800, 20'h186A0, 1'b0, 7'd4,  1'b1, 8'd1};
        tbl[5] = '{"avi_badck", 24'h0D0282, s_avi16_bad, 1'b1, 20'h01800, 20'h186A0, 1'b0, 7'd4,  1'b1, 8'd1};
        tbl[6] = '{"acr_mask",  24'h000001, s_acr2,      1'b1, 20'h789AB, 20'h23456, 1'b1, 7'd4,  1'b1, 8'd1};
        tbl[7] = '{"avi_ecc",   24'h0D0282, s_avi16,     1'b0, 20'h789AB, 20'h23456, 1'b0, 7'd4,  1'b1, 8'd2};
        tbl[8] = '{"type00",    24'h0D0200, s_avi16,     1'b1, 20'h789AB, 20'h23456, 1'b0, 7'd4,  1'b1, 8'd2};

        reset_n            = 1'b0;
        packet_valid       = 1'b0;
        packet_ecc_ok      = 1'b1;
        header             = '0;
        sub                = '0;
        audio_sample_ready = 1'b0;
        cycles(3);

        // Reset state
        chk("rst_valid", audio_sample_valid, 0);
        chk("rst_word",  audio_sample_word, 0);
        chk("rst_acr_n", acr_n, 0);
        chk("rst_ovf",   overflow_count, 0);
        chk("rst_ecc",   ecc_error_count, 0);
        reset_n = 1'b1;
        cycles(1);

        // Table-driven ACR / AVI / ECC / unlisted-type vectors
        for (int i = 0; i < 9; i++) begin
            send_pkt(tbl[i].hdr, tbl[i].sb, tbl[i].ok);
            chk({tbl[i].nm, "_n"},   acr_n,           tbl[i].n);
            chk({tbl[i].nm, "_cts"}, acr_cts,         tbl[i].cts);
            chk({tbl[i].nm, "_upd"}, acr_update,      tbl[i].upd);
            chk({tbl[i].nm, "_vic"}, vic,             tbl[i].vic);
            chk({tbl[i].nm, "_avi"}, avi_valid,       tbl[i].avi);
            chk({tbl[i].nm, "_ecc"}, ecc_error_count, tbl[i].ecc);
            cycles(1);
            chk({tbl[i].nm, "_upd_fall"}, acr_update, 0);
        end

        // Audio: four samples, ready held high, latency and order
        audio_sample_ready = 1'b1;
        q_pop.delete();
        send_pkt(24'h100F02, aud_sub(0), 1'b1);
        chk("aud_vld_T", audio_sample_valid, 0);
        cycles(1);
        chk("aud_vld_T1", audio_sample_valid, 0);
        cycles(1);
        chk("aud_vld_T2", audio_sample_valid, 1);
        chk("aud_head_T2", audio_sample_word, exp_word(0, 0));
        cycles(8);
        chk("aud4_count", q_pop.size(), 4);
        for (int i = 0; i < 4 && i < q_pop.size(); i++)
            chk($sformatf("aud4_w%0d", i), q_pop[i], {(i == 0), exp_word(0, i)});

        // Present mask 0x05 (slot 1 flat but absent)
        q_pop.delete();
        send_pkt(24'h020502, aud_sub(0), 1'b1);
        cycles(8);
        chk("mask05_count", q_pop.size(), 2);
        if (q_pop.size() == 2) begin
            chk("mask05_w0", q_pop[0], {1'b0, exp_word(0, 0)});
            chk("mask05_w1", q_pop[1], {1'b0, exp_word(0, 2)});
        end

        // Flat sample on a present slot
        q_pop.delete();
        send_pkt(24'h020302, aud_sub(0), 1'b1);
        cycles(8);
        chk("flat_count", q_pop.size(), 2);
        if (q_pop.size() == 2) begin
            chk("flat_w0", q_pop[0], {1'b0, exp_word(0, 0)});
            chk("flat_w1", q_pop[1], 33'h0);
        end

        // Layout 1 packet ignored
        q_pop.delete();
        send_pkt(24'h001F02, aud_sub(0), 1'b1);
        cycles(8);
        chk("layout1_count", q_pop.size(), 0);

        // Overflow: three full packets into an 8-deep FIFO with no consumer
        audio_sample_ready = 1'b0;
        q_pop.delete();
        for (int p = 0; p < 3; p++) begin
            send_pkt(24'h000F02, aud_sub(p), 1'b1);
            cycles(6);
        end
        chk("ovf_count", overflow_count, 4);
        chk("ovf_valid", audio_sample_valid, 1);
        chk("ovf_head",  audio_sample_word, exp_word(0, 0));
        audio_sample_ready = 1'b1;
        cycles(12);
        chk("drain_count", q_pop.size(), 8);
        for (int k = 0; k < 8 && k < q_pop.size(); k++)
            chk($sformatf("drain_w%0d", k), q_pop[k], {1'b0, exp_word(k / 4, k % 4)});
        chk("drain_empty_vld",  audio_sample_valid, 0);
        chk("drain_empty_word", audio_sample_word, 0);

        // ECC error counter saturation (count is 2 here)
        for (int i = 0; i < 300; i++) send_pkt(24'h000001, tbl[0].sb, 1'b0);
        chk("ecc_sat", ecc_error_count, 255);
        chk("ecc_no_acr", acr_n, 20'h789AB);

        // Reset asserted mid-UNPACK
        audio_sample_ready = 1'b0;
        send_pkt(24'h100F02, aud_sub(0), 1'b1);
        cycles(1);
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", audio_sample_valid, 0);
        chk("mrst_word",  audio_sample_word, 0);
        chk("mrst_bstart", audio_sample_block_start, 0);
        chk("mrst_acr",   {acr_n, acr_cts, acr_update}, 0);
        chk("mrst_avi",   {vic, avi_valid}, 0);
        chk("mrst_cnt",   {overflow_count, ecc_error_count}, 0);
        cycles(1);
        reset_n = 1'b1;
        cycles(8);
        chk("mrst_after_valid", audio_sample_valid, 0);
        chk("mrst_after_ovf",   overflow_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
